// File: rtl/tmds_decoder_align.sv
// -----------------------------------------------------------------------------
// tmds_decoder_align
//
// Purpose:
//   Word aligner and decoder for one TMDS channel.
//   - Holds the last two raw 10-bit words as a 20-bit serial window.
//   - Extracts the aligned word at the current bit offset.
//   - Hunts for the offset that yields a steady run of control tokens.
//   - Decodes aligned words into a video byte or a control pair.
//
// Optional feature:
//   Define TMDS_DECODER_STATS_EN to build the saturating lock-loss counter.
//   Without it, lock_loss_count is tied to zero.
//
// Parameters:
//   LOCK_COUNT    consecutive aligned control tokens needed to declare lock
//   SLIP_CYCLES   search cycles spent at one offset before slipping one bit
//   TIMEOUT_BITS  lock is dropped after 2^TIMEOUT_BITS cycles with no token
//
// Ports:
//   clk_pixel        in   1   pixel clock (single domain)
//   reset            in   1   asynchronous, active-high reset
//   tmds_raw         in  10   unaligned channel word, bit 0 received first
//   data             out  8   decoded video byte
//   ctl              out  2   decoded control pair {CD1,CD0}
//   de               out  1   1 = video data, 0 = control period
//   locked           out  1   word alignment achieved
//   align_offset     out  4   current bit-slip offset, 0..9
//   lock_loss_count  out  8   number of lock losses, saturating at 255
//
// Latency:
//   Three clk_pixel cycles from tmds_raw to the decoded outputs at offset 0.
//   - r1, r2: two capture stages.
//   - The aligned word is sliced combinationally from the registered window.
//   - The decoded outputs are registered.
//
// FSM states:
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ST_SEARCH | hunting: count token runs, slip the offset when the timer ends
//   ST_LOCKED | aligned: decode freely, watch for a long token-free gap
// -----------------------------------------------------------------------------
module tmds_decoder_align #(
  parameter int LOCK_COUNT   = 16,
  parameter int SLIP_CYCLES  = 1024,
  parameter int TIMEOUT_BITS = 12
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] tmds_raw,
  output logic [7:0] data,
  output logic [1:0] ctl,
  output logic       de,
  output logic       locked,
  output logic [3:0] align_offset,
  output logic [7:0] lock_loss_count
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int SLIP_W = (SLIP_CYCLES > 1) ? $clog2(SLIP_CYCLES) : 1;

  localparam logic [RUN_W-1:0]        RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [SLIP_W-1:0]       SLIP_LAST = SLIP_W'(SLIP_CYCLES - 1);
  localparam logic [TIMEOUT_BITS-1:0] TO_LAST   = '1;

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [9:0]              r1_q, r1_d;
  logic [9:0]              r2_q, r2_d;
  state_t                  state_q, state_d;
  logic [3:0]              offset_q, offset_d;
  logic [RUN_W-1:0]        run_q, run_d;
  logic [SLIP_W-1:0]       slip_q, slip_d;
  logic [TIMEOUT_BITS-1:0] to_q, to_d;
  logic [1:0]              ctl_last_q, ctl_last_d;
  logic [7:0]              data_q, data_d;
  logic [1:0]              ctl_q, ctl_d;
  logic                    de_q, de_d;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  // Bit 19 of the 20-bit window is never selected (max offset 9 -> bit 18).
  logic [18:0] window;
  logic [9:0]  aligned_w;
  logic        is_tok;
  logic [1:0]  tok_ctl;
  logic [3:0]  offset_inc;
  logic [7:0]  d_word;
  logic [6:0]  d_xor;
  logic [7:0]  dec_data;

  // ---------------------------------------------------------------------------
  // Input window and word slicing
  // ---------------------------------------------------------------------------
  assign r1_d = tmds_raw;
  assign r2_d = r1_q;

  // r2 holds the older word, so it forms the low (earlier) half of the window.
  assign window = {r1_q[8:0], r2_q};

  always_comb begin
    aligned_w = window[9:0];
    for (int k = 0; k < 10; k++) begin
      if (offset_q == 4'(k)) begin
        aligned_w = window[k +: 10];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control-token detection
  // ---------------------------------------------------------------------------
  always_comb begin
    is_tok  = 1'b1;
    tok_ctl = 2'b00;
    case (aligned_w)
      TOK_00:  tok_ctl = 2'b00;
      TOK_01:  tok_ctl = 2'b01;
      TOK_10:  tok_ctl = 2'b10;
      TOK_11:  tok_ctl = 2'b11;
      default: is_tok  = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Data decode
  // ---------------------------------------------------------------------------
  // q[9] undoes the DC-balancing inversion.
  // q[8] selects XOR versus XNOR chaining between adjacent bits.
  assign d_word   = aligned_w[9] ? ~aligned_w[7:0] : aligned_w[7:0];
  assign d_xor    = d_word[7:1] ^ d_word[6:0];
  assign dec_data = {(aligned_w[8] ? d_xor : ~d_xor), d_word[0]};

  assign offset_inc = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

  // ---------------------------------------------------------------------------
  // Alignment FSM: next state and counters
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    run_d    = run_q;
    slip_d   = slip_q;
    to_d     = to_q;

    case (state_q)
      ST_SEARCH: begin
        to_d = '0;
        if (is_tok && (run_q == RUN_LAST)) begin
          // Lock has priority over a coincident slip, so the offset stays put.
          state_d = ST_LOCKED;
          run_d   = '0;
          slip_d  = '0;
        end else begin
          run_d = is_tok ? run_q + RUN_W'(1) : '0;
          if (slip_q == SLIP_LAST) begin
            offset_d = offset_inc;
            slip_d   = '0;
            run_d    = '0;
          end else begin
            slip_d = slip_q + SLIP_W'(1);
          end
        end
      end

      ST_LOCKED: begin
        run_d  = '0;
        slip_d = '0;
        if (is_tok) begin
          to_d = '0;
        end else if (to_q == TO_LAST) begin
          // Timeout: resume the search one bit further on.
          state_d  = ST_SEARCH;
          offset_d = offset_inc;
          to_d     = '0;
        end else begin
          to_d = to_q + TIMEOUT_BITS'(1);
        end
      end

      default: begin
        state_d = ST_SEARCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  // The gate uses next-state lock, so the outputs and the locked flag change on
  // the same edge. The word that completes lock is decoded, and the word that
  // times lock out is blanked. ctl_last keeps tracking tokens while unlocked.
  always_comb begin
    ctl_last_d = is_tok ? tok_ctl : ctl_last_q;
    de_d       = 1'b0;
    data_d     = 8'h00;
    ctl_d      = 2'b00;
    if (state_d == ST_LOCKED) begin
      de_d   = ~is_tok;
      data_d = is_tok ? 8'h00 : dec_data;
      ctl_d  = ctl_last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r1_q       <= '0;
      r2_q       <= '0;
      state_q    <= ST_SEARCH;
      offset_q   <= '0;
      run_q      <= '0;
      slip_q     <= '0;
      to_q       <= '0;
      ctl_last_q <= '0;
      data_q     <= '0;
      ctl_q      <= '0;
      de_q       <= 1'b0;
    end else begin
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      state_q    <= state_d;
      offset_q   <= offset_d;
      run_q      <= run_d;
      slip_q     <= slip_d;
      to_q       <= to_d;
      ctl_last_q <= ctl_last_d;
      data_q     <= data_d;
      ctl_q      <= ctl_d;
      de_q       <= de_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock-loss statistics
  // ---------------------------------------------------------------------------
`ifdef TMDS_DECODER_STATS_EN
  logic [7:0] llc_q, llc_d;

  always_comb begin
    llc_d = llc_q;
    if ((state_q == ST_LOCKED) && (state_d == ST_SEARCH) && (llc_q != 8'hFF)) begin
      llc_d = llc_q + 8'd1;
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      llc_q <= '0;
    end else begin
      llc_q <= llc_d;
    end
  end

  assign lock_loss_count = llc_q;
`else
  assign lock_loss_count = 8'd0;
`endif

  assign data         = data_q;
  assign ctl          = ctl_q;
  assign de           = de_q;
  assign locked       = (state_q == ST_LOCKED);
  assign align_offset = offset_q;

endmodule

// File: tb/tb_tmds_decoder_align.sv
// -----------------------------------------------------------------------------
// tb_tmds_decoder_align
//
// Purpose:
//   Self-checking bench for tmds_decoder_align with default parameters.
//   - At offset 0, expectations are queued when each word is driven.
//   - Each expectation is checked when that word leaves the decoder,
//     three cycles later.
//   - Slip, wrap and timeout behaviour is checked at exact cycle counts,
//     counted from reset release.
// -----------------------------------------------------------------------------
module tb_tmds_decoder_align;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] D00 = 10'b0100000000;
  localparam logic [9:0] DFF = 10'b1000000000;

  logic       clk_pixel = 1'b0;
  logic       reset     = 1'b1;
  logic [9:0] tmds_raw  = '0;
  logic [7:0] data;
  logic [1:0] ctl;
  logic       de;
  logic       locked;
  logic [3:0] align_offset;
  logic [7:0] lock_loss_count;

  always #5 clk_pixel = ~clk_pixel;

  tmds_decoder_align dut (
    .clk_pixel       (clk_pixel),
    .reset           (reset),
    .tmds_raw        (tmds_raw),
    .data            (data),
    .ctl             (ctl),
    .de              (de),
    .locked          (locked),
    .align_offset    (align_offset),
    .lock_loss_count (lock_loss_count)
  );

  typedef struct {
    bit         chk;
    bit         lk;
    bit         de;
    logic [7:0] data;
    logic [1:0] ctl;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] exp_ctl = 2'b00;
  int         cyc     = 0;
  int         n_cmp   = 0;
  int         n_bad   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int tok_idx(input logic [9:0] q);
    case (q)
      T00:     return 0;
      T01:     return 1;
      T10:     return 2;
      T11:     return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] ref_data(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] o;
    for (int i = 0; i < 8; i++) d[i] = q[i] ^ q[9];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = (d[i] ^ d[i-1]) ^ ~q[8];
    return o;
  endfunction

  // Drive one word for one cycle. The expectation for the word is queued now
  // and checked when the word reaches the outputs, three edges later.
  task automatic step(input logic [9:0] w, input bit do_chk, input bit lk);
    exp_t e;
    int   ti;
    ti = tok_idx(w);
    if (ti >= 0) exp_ctl = 2'(ti);
    e.chk  = do_chk;
    e.lk   = lk;
    e.de   = 1'b0;
    e.data = 8'h00;
    e.ctl  = 2'b00;
    if (lk) begin
      e.ctl = exp_ctl;
      if (ti < 0) begin
        e.de   = 1'b1;
        e.data = ref_data(w);
      end
    end
    sb.push_back(e);
    tmds_raw = w;
    @(posedge clk_pixel);
    #1;
    cyc++;
    if (sb.size() == 3) begin
      e = sb.pop_front();
      if (e.chk) begin
        chk_eq("sb_locked", 32'(locked), 32'(e.lk));
        chk_eq("sb_de",     32'(de),     32'(e.de));
        chk_eq("sb_data",   32'(data),   32'(e.data));
        chk_eq("sb_ctl",    32'(ctl),    32'(e.ctl));
      end
    end
  endtask

  // Hold reset for n cycles of random input, then release it just after an
  // edge so that the next edge is the first capture.
  task automatic do_reset(input int n);
    reset = 1'b1;
    sb.delete();
    exp_ctl = 2'b00;
    repeat (n) begin
      tmds_raw = 10'($urandom);
      @(posedge clk_pixel);
    end
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    logic [9:0] w;
    logic [9:0] wslip;
    int         nxt;
    logic [7:0] exp_llc;

`ifdef TMDS_DECODER_STATS_EN
    exp_llc = 8'd1;
`else
    exp_llc = 8'd0;
`endif

    // Reset behaviour with random input.
    repeat (5) begin
      tmds_raw = 10'($urandom);
      @(posedge clk_pixel);
    end
    #1;
    chk_eq("rst_locked", 32'(locked), 32'd0);
    chk_eq("rst_de",     32'(de),     32'd0);
    chk_eq("rst_data",   32'(data),   32'd0);
    chk_eq("rst_ctl",    32'(ctl),    32'd0);
    chk_eq("rst_offset", 32'(align_offset), 32'd0);
    chk_eq("rst_llc",    32'(lock_loss_count), 32'd0);
    reset = 1'b0;
    cyc = 0;

    // Aligned lock: 16 tokens, then a 0x00 data word and a 0xFF data word.
    for (int i = 1; i <= 16; i++) step(T00, 1'b1, i == 16);
    step(D00, 1'b1, 1'b1);
    step(DFF, 1'b1, 1'b1);
    chk_eq("lock_offset", 32'(align_offset), 32'd0);

    // Mixed random data and tokens while locked.
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) begin
        case ($urandom_range(0, 3))
          0:       w = T00;
          1:       w = T01;
          2:       w = T10;
          default: w = T11;
        endcase
      end else begin
        w = 10'($urandom);
      end
      step(w, 1'b1, 1'b1);
    end

    // Lock loss: one token, then 4096 data words. The last word times out.
    step(T00, 1'b1, 1'b1);
    for (int i = 1; i <= 4096; i++) step(D00, 1'b1, i < 4096);
    step(D00, 1'b1, 1'b0);
    step(D00, 1'b1, 1'b0);
    chk_eq("loss_locked", 32'(locked), 32'd0);
    chk_eq("loss_offset", 32'(align_offset), 32'd1);
    chk_eq("loss_llc",    32'(lock_loss_count), 32'(exp_llc));

    // Bit slip: a T01 stream delayed by 3 bits locks at offset 3.
    for (int j = 0; j < 10; j++) wslip[j] = T01[(j + 7) % 10];
    do_reset(2);
    for (int i = 0; i < 3100; i++) begin
      step(wslip, 1'b0, 1'b0);
      if (cyc == 1023) chk_eq("slip_off_1023", 32'(align_offset), 32'd0);
      if (cyc == 1024) chk_eq("slip_off_1024", 32'(align_offset), 32'd1);
      if (cyc == 2048) chk_eq("slip_off_2048", 32'(align_offset), 32'd2);
      if (cyc == 3072) chk_eq("slip_off_3072", 32'(align_offset), 32'd3);
      if (cyc == 3087) chk_eq("slip_unlocked", 32'(locked), 32'd0);
      if (cyc == 3088) chk_eq("slip_locked",   32'(locked), 32'd1);
      if (cyc == 3090) begin
        chk_eq("slip_ctl",    32'(ctl), 32'd1);
        chk_eq("slip_de",     32'(de),  32'd0);
        chk_eq("slip_offset", 32'(align_offset), 32'd3);
      end
    end

    // Mid-lock reset: asynchronous clear, then a fresh lock at offset 0.
    reset = 1'b1;
    #1;
    chk_eq("mrst_locked", 32'(locked), 32'd0);
    chk_eq("mrst_offset", 32'(align_offset), 32'd0);
    chk_eq("mrst_llc",    32'(lock_loss_count), 32'd0);
    sb.delete();
    exp_ctl = 2'b00;
    @(posedge clk_pixel);
    #1;
    reset = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 16; i++) step(T10, 1'b1, i == 16);
    step(10'($urandom), 1'b1, 1'b1);
    step(D00, 1'b1, 1'b1);
    chk_eq("relock_offset", 32'(align_offset), 32'd0);

    // Wrap from 9 to 0. Then the 16th token lands on the slip-expiry edge.
    do_reset(2);
    while (cyc < 11270) begin
      nxt = cyc + 1;
      w = (nxt >= 11247 && nxt <= 11262) ? T11 : D00;
      step(w, 1'b0, 1'b0);
      if (cyc == 9215)  chk_eq("wrap_off_9215",  32'(align_offset), 32'd8);
      if (cyc == 9216)  chk_eq("wrap_off_9216",  32'(align_offset), 32'd9);
      if (cyc == 10239) chk_eq("wrap_off_10239", 32'(align_offset), 32'd9);
      if (cyc == 10240) chk_eq("wrap_off_10240", 32'(align_offset), 32'd0);
      if (cyc == 11263) chk_eq("sim_unlocked",   32'(locked), 32'd0);
      if (cyc == 11264) begin
        chk_eq("sim_locked", 32'(locked), 32'd1);
        chk_eq("sim_offset", 32'(align_offset), 32'd0);
      end
      if (cyc == 11266) chk_eq("sim_ctl", 32'(ctl), 32'd3);
      if (cyc == 11270) chk_eq("sim_offset_hold", 32'(align_offset), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
